zap_wb_ram_responder: RTL

ZAP_WB_RAM_RESPONDER -- requirements
Module: zap_wb_ram_responder

---
 rtl/zap_wb_ram_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/zap_wb_ram_responder.sv
// Wishbone RAM slave: word-addressed memory with WAIT_STATES idle cycles before the first ack, then zero-wait incrementing bursts.
// Ack, err and read data are registered. Beats at or beyond DEPTH answer with err and are never written.
module zap_wb_ram_responder #(
    parameter int unsigned DEPTH       = 32'd1024,
    parameter int unsigned WAIT_STATES = 32'd1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_busy
);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] adr_q, adr_d;
    logic [29:0] rd_adr;
    logic        rd_en;
    logic        ack_d, err_d;
    logic        wr_en;
    logic [31:0] mem [DEPTH];

    logic unused_adr_lsb;
    assign unused_adr_lsb = ^i_wb_adr[1:0];

    function automatic logic in_range(input logic [29:0] a);
        return ({2'b00, a} < DEPTH);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        rd_adr  = adr_q;
        rd_en   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    adr_d = i_wb_adr[31:2];
                    if (WS4 == 4'd0) begin
                        state_d = BURST;
                        rd_adr  = i_wb_adr[31:2];
                        rd_en   = 1'b1;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS4;
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // counter expires here; the first beat is answered only if stb is still present
                    cnt_d = 4'd0;
                    if (i_wb_stb) begin
                        state_d = BURST;
                        rd_en   = 1'b1;
                    end
                end
            end
            BURST: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else if (o_wb_ack || o_wb_err) begin
                    // a presented beat with stb low is not a transfer: retract and hold the address
                    if (i_wb_stb) begin
                        if (i_wb_cti == 3'b010) begin
                            adr_d  = adr_q + 30'd1;
                            rd_adr = adr_q + 30'd1;
                            rd_en  = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else if (i_wb_stb) begin
                    rd_en = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rd_en) begin
            ack_d = in_range(rd_adr);
            err_d = !in_range(rd_adr);
        end
    end

    assign wr_en = i_reset_n && (state_q == BURST) && o_wb_ack &&
                   i_wb_cyc && i_wb_stb && i_wb_wen;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    mem[adr_q[AW-1:0]][8*b +: 8] <= i_wb_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            adr_q    <= 30'd0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            o_wb_ack <= ack_d;
            o_wb_err <= err_d;
            o_wb_dat <= ack_d ? mem[rd_adr[AW-1:0]] : 32'd0;
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule
